// File: rtl/dmem_responder_if.sv
// Load/store bus between a requester (master) and the data-memory responder (slave).
// Both channels use valid/ready: a beat transfers on a rising edge where valid & ready are both 1;
// the sender holds valid and its payload stable until that edge, and ready never depends on the payload.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data RAM behind a one-outstanding-request load/store handshake with
// WAIT_STATES cycles of access latency; misaligned or out-of-range requests return err.
module dmem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  dmem_responder_if.slave   bus,
  output logic [1:0]        state_dbg
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  logic          cap_we;
  logic [31:0]   cap_addr;
  logic [31:0]   cap_wdata;
  logic [3:0]    cap_be;

  logic          req_ready_q;
  logic          rsp_valid_q;
  logic          rsp_err_q;
  logic [31:0]   rsp_rdata_q;

  logic [31:0]   ram [DEPTH];

  logic          accept;
  logic          acc_fire;
  logic          acc_we;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [3:0]    acc_be;
  logic          acc_err;
  logic [AW-1:0] acc_idx;
  logic [31:0]   acc_rdata;

  assign accept = bus.req_valid & req_ready_q;

  // With no wait states the access happens on the accept edge itself, straight from the bus.
  always_comb begin
    acc_fire  = 1'b0;
    acc_we    = cap_we;
    acc_addr  = cap_addr;
    acc_wdata = cap_wdata;
    acc_be    = cap_be;
    if (WAIT_STATES == 0) begin
      acc_fire  = accept;
      acc_we    = bus.req_we;
      acc_addr  = bus.req_addr;
      acc_wdata = bus.req_wdata;
      acc_be    = bus.req_be;
    end else begin
      acc_fire  = (state == S_WAIT) && (cnt == '0);
    end
    acc_err   = (acc_addr[1:0] != 2'b00) || ({2'b00, acc_addr[31:2]} >= 32'(DEPTH));
    acc_idx   = acc_addr[2 +: AW];
    acc_rdata = (acc_err || acc_we) ? 32'h0 : ram[acc_idx];
  end

  // RAM is deliberately outside reset; reset forces IDLE asynchronously, which blocks any pending write.
  always_ff @(posedge clk) begin
    if (acc_fire && acc_we && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) ram[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      cap_we      <= 1'b0;
      cap_addr    <= '0;
      cap_wdata   <= '0;
      cap_be      <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cap_we      <= bus.req_we;
            cap_addr    <= bus.req_addr;
            cap_wdata   <= bus.req_wdata;
            cap_be      <= bus.req_be;
            req_ready_q <= 1'b0;
            if (WAIT_STATES == 0) begin
              state       <= S_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= acc_err;
              rsp_rdata_q <= acc_rdata;
            end else begin
              state <= S_WAIT;
              cnt   <= CW'(WAIT_STATES - 1);
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            state       <= S_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= acc_err;
            rsp_rdata_q <= acc_rdata;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_RESP: begin
          // Ready rises with the return to IDLE so a held request is accepted on the first IDLE cycle.
          if (bus.rsp_ready) begin
            state       <= S_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= S_IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign state_dbg     = state;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a WAIT_STATES=2 instance (vectors, random traffic, backpressure, reset
// mid-access) and a WAIT_STATES=0 instance (single-cycle latency and back-to-back throughput).
module tb_dmem_responder;
  localparam int DEPTH = 64;

  logic clk;
  logic reset_n;
  logic [1:0] state_a, state_b;

  dmem_responder_if bus_a ();
  dmem_responder_if bus_b ();

  dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a), .state_dbg(state_a));
  dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b), .state_dbg(state_b));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  // ---------------- checking ----------------
  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%h expected=%h", name, act, exp);
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] ref_mem [DEPTH];
  logic [32:0] exp_q [$];

  task automatic model_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be);
    logic        e;
    logic [31:0] r;
    int          w;
    w = int'(addr / 4);
    e = (addr % 4 != 0) || (addr / 4 >= DEPTH);
    r = 32'h0;
    if (!e && we) begin
      for (int i = 0; i < 4; i++)
        if (be[i]) ref_mem[w][8*i +: 8] = wdata[8*i +: 8];
    end else if (!e) begin
      r = ref_mem[w];
    end
    exp_q.push_back({e, r});
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit sel, input logic v, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input logic rr);
    if (sel) begin
      bus_b.req_valid = v; bus_b.req_we = we; bus_b.req_addr = addr;
      bus_b.req_wdata = wdata; bus_b.req_be = be; bus_b.rsp_ready = rr;
    end else begin
      bus_a.req_valid = v; bus_a.req_we = we; bus_a.req_addr = addr;
      bus_a.req_wdata = wdata; bus_a.req_be = be; bus_a.rsp_ready = rr;
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? bus_b.req_ready : bus_a.req_ready;
  endfunction

  function automatic logic rvld(input bit sel);
    return sel ? bus_b.rsp_valid : bus_a.rsp_valid;
  endfunction

  // Called on a falling edge; returns on a falling edge after the response handshake.
  // lat = falling edges from the accept edge up to the first one showing rsp_valid.
  task automatic run_req(input bit sel, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be,
                         output logic [31:0] rdata, output logic err, output int lat);
    int guard;
    drive(sel, 1'b1, we, addr, wdata, be, 1'b1);
    guard = 0;
    while (rdy(sel) !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      check("accept_timeout", 32'(guard), 32'd0);
      drive(sel, 1'b0, we, addr, wdata, be, 1'b1);
      rdata = 'x; err = 1'bx; lat = 0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    drive(sel, 1'b0, we, addr, wdata, be, 1'b1);
    lat = 1;
    while (rvld(sel) !== 1'b1 && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    rdata = sel ? bus_b.rsp_rdata : bus_a.rsp_rdata;
    err   = sel ? bus_b.rsp_err   : bus_a.rsp_err;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic scored_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, input string tag);
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic [32:0] e;
    model_op(we, addr, wdata, be);
    run_req(1'b0, we, addr, wdata, be, rd, er, lat);
    e = exp_q.pop_front();
    check({tag, "_err"},   32'(er), 32'(e[32]));
    check({tag, "_rdata"}, rd, e[31:0]);
    check({tag, "_lat"},   32'(lat), 32'd3);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl [12];

  initial begin
    logic [31:0] rd, old, hold;
    logic        er;
    logic [32:0] e;
    int          lat, guard, n_acc, last_acc;
    string       nm;

    tbl[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 32'h10,  32'h0,        4'hF, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h10,  32'h000000AA, 4'h1, 32'h0,        1'b0};
    tbl[3]  = '{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEAA, 1'b0};
    tbl[4]  = '{1'b1, 32'h0,   32'h0BADF00D, 4'hF, 32'h0,        1'b0};
    tbl[5]  = '{1'b0, 32'h12,  32'h0,        4'hF, 32'h0,        1'b1};
    tbl[6]  = '{1'b1, 32'h100, 32'h12345678, 4'hF, 32'h0,        1'b1};
    tbl[7]  = '{1'b0, 32'h0,   32'h0,        4'hF, 32'h0BADF00D, 1'b0};
    tbl[8]  = '{1'b1, 32'h10,  32'hFFFFFFFF, 4'h0, 32'h0,        1'b0};
    tbl[9]  = '{1'b0, 32'h10,  32'h0,        4'hF, 32'hDEADBEAA, 1'b0};
    tbl[10] = '{1'b1, 32'hFC,  32'hCAFEF00D, 4'hC, 32'h0,        1'b0};
    tbl[11] = '{1'b0, 32'hFC,  32'h0,        4'hF, 32'h0,        1'b0};

    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_req_ready", 32'(bus_a.req_ready), 32'd0);
    check("rst_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
    check("rst_rsp_rdata", bus_a.rsp_rdata, 32'h0);
    check("rst_rsp_err",   32'(bus_a.rsp_err), 32'd0);
    check("rst_state",     32'(state_a), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("idle_req_ready", 32'(bus_a.req_ready), 32'd1);

    // Give every word a known value so the model can predict every load.
    for (int i = 0; i < DEPTH; i++)
      scored_op(1'b1, 32'(i * 4), $urandom, 4'hF, "fill");

    // The last word's expected value depends on the fill, so derive it before applying.
    tbl[11].exp_rdata = {32'hCAFE0000 | (ref_mem[63] & 32'h0000FFFF)};
    for (int i = 0; i < 12; i++) begin
      model_op(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be);
      void'(exp_q.pop_front());
      run_req(1'b0, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be, rd, er, lat);
      nm = $sformatf("vec%0d", i);
      check({nm, "_err"},   32'(er), 32'(tbl[i].exp_err));
      check({nm, "_rdata"}, rd, tbl[i].exp_rdata);
      check({nm, "_lat"},   32'(lat), 32'd3);
    end

    // Random traffic against the model.
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a;
      case ($urandom_range(0, 9))
        0:       a = {24'h0, 2'b00, 6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
        1:       a = ($urandom | 32'h100) & 32'hFFFF_FFFC;
        default: a = 32'($urandom_range(0, 63)) * 4;
      endcase
      scored_op(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), "rand");
    end

    // Backpressure: response must hold while rsp_ready is low.
    model_op(1'b0, 32'h10, 32'h0, 4'hF);
    e = exp_q.pop_front();
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0);
    guard = 0;
    while (bus_a.req_ready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0);
    guard = 0;
    while (bus_a.rsp_valid !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
    check("bp_wait", 32'(guard), 32'd2);
    for (int k = 0; k < 5; k++) begin
      check("bp_rsp_valid", 32'(bus_a.rsp_valid), 32'd1);
      check("bp_rsp_rdata", bus_a.rsp_rdata, e[31:0]);
      check("bp_req_ready", 32'(bus_a.req_ready), 32'd0);
      @(negedge clk);
    end
    bus_a.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_idle_state", 32'(state_a), 32'd0);
    check("bp_rsp_valid_low", 32'(bus_a.rsp_valid), 32'd0);
    check("bp_req_ready_high", 32'(bus_a.req_ready), 32'd1);

    // Reset during WAIT of a store: the store must be dropped.
    old = ref_mem[8];
    drive(1'b0, 1'b1, 1'b1, 32'h20, ~old, 4'hF, 1'b1);
    guard = 0;
    while (bus_a.req_ready !== 1'b1 && guard < 50) begin @(negedge clk); guard++; end
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1);
    check("rw_in_wait", 32'(state_a), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rw_rsp_valid", 32'(bus_a.rsp_valid), 32'd0);
    check("rw_req_ready", 32'(bus_a.req_ready), 32'd0);
    check("rw_state", 32'(state_a), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    scored_op(1'b0, 32'h20, 32'h0, 4'hF, "rw_reload");

    // Zero-wait-state instance.
    hold = 32'h5A5A1234;
    run_req(1'b1, 1'b1, 32'h8, hold, 4'hF, rd, er, lat);
    check("z_store_err", 32'(er), 32'd0);
    check("z_store_lat", 32'(lat), 32'd1);
    run_req(1'b1, 1'b0, 32'h8, 32'h0, 4'hF, rd, er, lat);
    check("z_load_rdata", rd, hold);
    check("z_load_lat", 32'(lat), 32'd1);
    run_req(1'b1, 1'b0, 32'h9, 32'h0, 4'hF, rd, er, lat);
    check("z_mis_err", 32'(er), 32'd1);
    check("z_mis_rdata", rd, 32'h0);

    drive(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF, 1'b1);
    n_acc = 0;
    last_acc = -1;
    for (int c = 0; c < 20; c++) begin
      if (bus_b.req_ready === 1'b1) begin
        if (last_acc >= 0) check("z_b2b_gap", 32'(c - last_acc), 32'd2);
        last_acc = c;
        n_acc++;
      end
      if (bus_b.rsp_valid === 1'b1) check("z_b2b_rdata", bus_b.rsp_rdata, hold);
      @(negedge clk);
    end
    bus_b.req_valid = 1'b0;
    check("z_b2b_accepts", 32'(n_acc), 32'd10);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
